// File: rtl/decoder_pkg.sv
// Shared types and the decode function for the streaming binary decoder.
package decoder_pkg;

  // Largest index/vector widths dec_vec can produce; callers truncate to their own width.
  localparam int DEC_MAX_IN_W  = 8;
  localparam int DEC_MAX_OUT_W = 256;

  typedef enum logic [1:0] {
    DEC_ONEHOT   = 2'b00,
    DEC_THERMO   = 2'b01,
    DEC_ONEHOT_N = 2'b10,
    DEC_RSVD     = 2'b11
  } dec_mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  // Bits at or above out_w stay zero; an index >= out_w naturally yields the
  // out-of-range patterns (one-hot zeros, thermometer ones, active-low ones).
  function automatic logic [DEC_MAX_OUT_W-1:0] dec_vec(
    input logic [DEC_MAX_IN_W-1:0] a,
    input dec_mode_t               mode,
    input logic                    en,
    input int unsigned             out_w
  );
    logic [DEC_MAX_OUT_W-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < DEC_MAX_OUT_W; i++) begin
      if (i < out_w) begin
        case (mode)
          DEC_ONEHOT:   y[i] = en && (i == 32'(a));
          DEC_THERMO:   y[i] = en && (i <= 32'(a));
          DEC_ONEHOT_N: y[i] = !(en && (i == 32'(a)));
          default:      y[i] = 1'b0;
        endcase
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/decoder_skid.sv
// Two-entry valid/ready skid buffer: output register plus one overflow entry.
module decoder_skid
  import decoder_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_q, state_d;
  logic         in_ready_q;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         emit;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    accept  = in_valid && in_ready_q;
    emit    = (state_q != ST_EMPTY) && out_ready;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = in_data;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          out_d = in_data;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain of the skid entry can happen.
        if (emit) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments; the data entries are reset too so
    // nothing stale survives a reset taken while the buffer is full.
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_q;

endmodule

// File: rtl/decoder_stream.sv
// Pipelined binary decoder over valid/ready: decodes at accept time, buffers
// the result in a skid buffer and counts accepted transactions.
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int IN_W    = 5,
  parameter int OUT_W   = 2**IN_W,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_a,
  input  logic [1:0]         in_mode,
  input  logic               in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_y,
  output logic [IN_W-1:0]    out_a,
  output logic               out_oor,
  output logic [COUNT_W-1:0] txn_count
);

  localparam int PAY_W = OUT_W + IN_W + 1;

  logic [OUT_W-1:0]   dec_y;
  logic               dec_oor;
  logic [PAY_W-1:0]   pay_out;
  logic               accept;
  logic [COUNT_W-1:0] txn_count_q, txn_count_d;

  always_comb begin
    dec_y   = OUT_W'(dec_vec(DEC_MAX_IN_W'(in_a), dec_mode_t'(in_mode), in_en, OUT_W));
    dec_oor = (32'(in_a) >= 32'(OUT_W));
  end

  decoder_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({dec_oor, in_a, dec_y}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_oor, out_a, out_y} = pay_out;

  // Wraps naturally at 2**COUNT_W.
  assign accept      = in_valid && in_ready;
  assign txn_count_d = accept ? txn_count_q + COUNT_W'(1) : txn_count_q;

  always_ff @(posedge clk) begin
    if (!rst) txn_count_q <= '0;
    else      txn_count_q <= txn_count_d;
  end

  assign txn_count = txn_count_q;

endmodule

// File: doc/decoder_stream.md
Name: decoder_stream

Overview:
- Parametrised, pipelined successor to the 5-to-32 combinational decoder used by the MIPS datapath (register-file write-enable, control one-hots).
- Accepts a binary index over a valid/ready stream and returns the decoded vector one cycle later.
- Output vector is one-hot, thermometer or active-low one-hot, selected per transaction.
- A 2-entry skid buffer absorbs downstream backpressure with no bubbles.
- A running transaction counter supports self-checking benches and performance counters.

Parameters:
- IN_W, 5, width of binary index input.
- OUT_W, 2**IN_W, width of decoded output; must satisfy 1 <= OUT_W <= 2**IN_W.
- COUNT_W, 16, width of accepted-transaction counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream has a transaction.
- in_ready  output  1  block can accept; registered.
- in_a  input  IN_W  binary index.
- in_mode  input  2  00 one-hot, 01 thermometer, 10 active-low one-hot, 11 reserved (all-zero output).
- in_en  input  1  0 forces the decoded output to the mode's idle pattern (zeros, or ones for 10); the transaction is still passed.
- out_valid  output  1  output holds a transaction.
- out_ready  input  1  downstream accepts.
- out_y  output  OUT_W  decoded vector.
- out_a  output  IN_W  echo of the index.
- out_oor  output  1  index >= OUT_W (out of range).
- txn_count  output  COUNT_W  number of accepted input transactions.

Behaviour:
- Reset: rst==0 at a rising edge clears both buffer entries and txn_count. Registered outputs go to out_valid=0, out_y=0, out_a=0, out_oor=0, txn_count=0 and in_ready=1 on the next cycle.
- Reset mid-operation discards buffered data; no partial outputs are produced.
- Accept: in_valid && in_ready at a rising edge. Emit: out_valid && out_ready at a rising edge.
- Latency: a transaction accepted at edge k has out_valid=1 from edge k onward, i.e. first visible in cycle k+1, when the output entry is free or emitting at k.
- Decode is computed at accept time and stored, so later changes to in_* do not affect buffered data.
- One-hot: y[i] = (i == a).
- Thermometer: y[i] = (i <= a).
- Active-low one-hot: ~(one-hot).
- Out-of-range index (a >= OUT_W):
  - out_oor=1.
  - one-hot gives all zeros; thermometer gives all ones; active-low gives all ones.
- in_en=0 gives idle pattern; out_oor is still computed from a.
- Storage: output register plus one skid entry.
  - States: EMPTY (0 entries), ONE (output valid, skid empty), FULL (both valid).
  - EMPTY --accept--> ONE.
  - ONE --accept & no emit--> FULL.
  - ONE --emit & no accept--> EMPTY.
  - ONE --accept & emit--> ONE, with the output register reloaded.
  - FULL --emit--> ONE, with skid moved to output. No accept is possible in FULL.
- in_ready = (state != FULL), registered from the next-state value. out_valid = (state != EMPTY).
- Order is strictly FIFO; no transaction is dropped or duplicated.
- Output stability: while out_valid && !out_ready, out_y, out_a and out_oor hold constant.
- txn_count increments by 1 per accept and wraps from 2**COUNT_W-1 to 0 without saturation.
- Simultaneous accept and emit in ONE gives full throughput: 1 transaction per cycle sustained.

Decomposition:
- Package decoder_pkg holds:
  - typedef enum logic [1:0] dec_mode_t {DEC_ONEHOT, DEC_THERMO, DEC_ONEHOT_N, DEC_RSVD}.
  - typedef enum buffer state {ST_EMPTY, ST_ONE, ST_FULL}.
  - Pure function dec_vec(a, mode, en), parametrised via module-local width localparams or a parametrised class wrapper.
- One sub-module is natural: decoder_skid, a generic 2-entry valid/ready skid buffer of payload width OUT_W+IN_W+1, instantiated once.

Test Plan:
- Reset: hold rst=0 three cycles while in_valid=1 -> out_valid=0, out_y=0, txn_count=0. Release -> in_ready=1 next cycle.
- Exhaustive one-hot: IN_W=5, a=0..31, mode=00, out_ready=1 -> out_y = 1<<a one cycle after each accept. Then 32 results, 0 errors, txn_count=32.
- Mixed modes: a=5 -> thermometer 32'h0000003F; active-low 32'hFFFFFFDF; en=0 with one-hot 32'h00000000; mode=11 32'h00000000.
- Out of range: OUT_W=20, a=25, mode=01 -> out_y=20'hFFFFF and out_oor=1. Same a with mode=00 -> out_y=0 and out_oor=1.
- Backpressure: send a=1,2,3 back-to-back with out_ready=0 -> in_ready falls after 2 accepts and out_y holds 32'h2. Raise out_ready -> outputs 2,4,8 in order, no loss.
- Counter wrap: COUNT_W=4, 17 accepts -> txn_count=1. Reset asserted with FULL state -> all entries cleared, no stale output after release.
